// File: rtl/dlx_mem_pkg.sv
// Shared types and constants for the DLX data-memory responder.
// Bit vectors use big-endian numbering ([0:31]), so bit 0 is the MSB.
package dlx_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } mem_size_t;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } mem_state_t;

  // In a [0:3] mask, lane 0 is the leftmost bit and holds data bits [0:7].
  // Shifting a mask right moves it towards higher byte offsets.
  localparam logic [0:3] LANES_BYTE = 4'b1000;
  localparam logic [0:3] LANES_HALF = 4'b1100;
  localparam logic [0:3] LANES_WORD = 4'b1111;

  // When both flags are set, the byte flag wins.
  function automatic mem_size_t size_decode(input logic is_byte, input logic is_half);
    if (is_byte)
      return SZ_BYTE;
    else if (is_half)
      return SZ_HALF;
    else
      return SZ_WORD;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Steering between a 32-bit memory word and the processor's right-justified
// sub-word data, in both directions (load extraction, store lane placement).
module mem_lane_align
  import dlx_mem_pkg::*;
(
  input  logic [0:31] word,
  input  logic [0:1]  offset,
  input  mem_size_t   size,
  input  logic        sign_ext,
  input  logic [0:31] store_data,
  output logic [0:31] load_data,
  output logic [0:3]  lane_mask,
  output logic [0:31] lane_data
);

  logic [0:7]  sel_byte;
  logic [0:15] sel_half;

  always_comb begin
    sel_byte = word[0:7];
    case (offset)
      2'd0: sel_byte = word[0:7];
      2'd1: sel_byte = word[8:15];
      2'd2: sel_byte = word[16:23];
      2'd3: sel_byte = word[24:31];
      default: sel_byte = word[0:7];
    endcase
    // offset[0] is the MSB of the offset, i.e. it selects the upper/lower half.
    sel_half = offset[0] ? word[16:31] : word[0:15];
  end

  always_comb begin
    load_data = word;
    lane_mask = LANES_WORD;
    lane_data = store_data;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & sel_byte[0]}}, sel_byte};
        lane_mask = LANES_BYTE >> offset;
        lane_data = {4{store_data[24:31]}};
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & sel_half[0]}}, sel_half};
        lane_mask = LANES_HALF >> {offset[0], 1'b0};
        lane_data = {2{store_data[16:31]}};
      end
      default: begin
        load_data = word;
        lane_mask = LANES_WORD;
        lane_data = store_data;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the DMEM interface. It serves combinational loads and
// lane-masked stores, and it clears the whole array after every reset.
module dmem_responder
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] addr_from_proc,
  input  logic        write_enable_from_proc,
  input  logic        byte_from_proc,
  input  logic        half_word_from_proc,
  input  logic        sign_extend_from_proc,
  input  logic [0:31] data_from_proc,
  output logic [0:31] data_to_proc,
  output logic        init_busy,
  output logic        err_misaligned,
  output logic        err_range,
  output logic [31:0] store_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  mem_state_t state, state_next;
  logic [ADDR_BITS-1:0] clr_idx;
  logic [0:31] mem [DEPTH];

  logic [ADDR_BITS-1:0] word_idx;
  logic [0:1]  offset;
  mem_size_t   size;
  logic        out_of_range;
  logic        misaligned;
  logic        ready;
  logic        access_ok;
  logic        store_commit;

  logic [0:31] rd_word;
  logic [0:31] load_data;
  logic [0:3]  lane_mask;
  logic [0:31] lane_data;

  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_idx;
  logic [0:3]           wr_mask;
  logic [0:31]          wr_data;

  assign word_idx     = addr_from_proc[30-ADDR_BITS:29];
  assign offset       = addr_from_proc[30:31];
  assign size         = size_decode(byte_from_proc, half_word_from_proc);
  assign out_of_range = |addr_from_proc[0:29-ADDR_BITS];
  assign misaligned   = ((size == SZ_HALF) && addr_from_proc[31]) ||
                        ((size == SZ_WORD) && (addr_from_proc[30:31] != 2'b00));
  assign ready        = (state == ST_READY);
  assign access_ok    = ready && !out_of_range && !misaligned;
  assign store_commit = access_ok && write_enable_from_proc;

  // The read happens before the write, so a store to the same word still shows the old value this cycle.
  assign rd_word = mem[word_idx];

  mem_lane_align u_lane_align (
    .word       (rd_word),
    .offset     (offset),
    .size       (size),
    .sign_ext   (sign_extend_from_proc),
    .store_data (data_from_proc),
    .load_data  (load_data),
    .lane_mask  (lane_mask),
    .lane_data  (lane_data)
  );

  assign data_to_proc = access_ok ? load_data : '0;

  always_ff @(posedge clock) begin
    if (reset)
      state <= ST_CLEAR;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    init_busy  = 1'b0;
    case (state)
      ST_CLEAR: begin
        init_busy = 1'b1;
        if (clr_idx == ADDR_BITS'(DEPTH - 1))
          state_next = ST_READY;
      end
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_CLEAR;
    endcase
  end

  // The clear sweep and processor stores share the array's only write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_mask = lane_mask;
    wr_data = lane_data;
    if (state == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx;
      wr_mask = LANES_WORD;
      wr_data = '0;
    end else if (store_commit) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (wr_mask[lane])
          mem[wr_idx][8*lane +: 8] <= wr_data[8*lane +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      clr_idx <= '0;
    else if (state == ST_CLEAR)
      clr_idx <= clr_idx + 1'b1;
  end

  // A range fault takes precedence, so a misaligned out-of-range access raises only err_range.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_misaligned <= 1'b0;
      err_range      <= 1'b0;
    end else if (ready) begin
      if (out_of_range)
        err_range <= 1'b1;
      else if (misaligned)
        err_misaligned <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      store_count <= '0;
    else if (store_commit)
      store_count <= store_count + 32'd1;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder with a 16-word array.
module tb_dmem_responder;

  localparam int AB    = 4;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr_from_proc = '0;
  logic        write_enable_from_proc = 1'b0;
  logic        byte_from_proc = 1'b0;
  logic        half_word_from_proc = 1'b0;
  logic        sign_extend_from_proc = 1'b0;
  logic [31:0] data_from_proc = '0;
  logic [31:0] data_to_proc;
  logic        init_busy;
  logic        err_misaligned;
  logic        err_range;
  logic [31:0] store_count;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] model[DEPTH];

  dmem_responder #(.ADDR_BITS(AB)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .addr_from_proc         (addr_from_proc),
    .write_enable_from_proc (write_enable_from_proc),
    .byte_from_proc         (byte_from_proc),
    .half_word_from_proc    (half_word_from_proc),
    .sign_extend_from_proc  (sign_extend_from_proc),
    .data_from_proc         (data_from_proc),
    .data_to_proc           (data_to_proc),
    .init_busy              (init_busy),
    .err_misaligned         (err_misaligned),
    .err_range              (err_range),
    .store_count            (store_count)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_expect(input string tag, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic check_output();
    logic [31:0] exp;
    string tag;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboard_empty: observed %h expected none", data_to_proc);
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      check_value(tag, data_to_proc, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic we, input logic b,
                                input logic h, input logic sext, input logic [31:0] data);
    addr_from_proc         = addr;
    write_enable_from_proc = we;
    byte_from_proc         = b;
    half_word_from_proc    = h;
    sign_extend_from_proc  = sext;
    data_from_proc         = data;
  endtask

  task automatic idle();
    apply_stimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // The load stays on the bus across the next clock edge, so error flags see it.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic b,
                         input logic h, input logic sext, input logic [31:0] exp);
    @(posedge clock); #1;
    apply_stimulus(addr, 1'b0, b, h, sext, 32'h0);
    push_expect(tag, exp);
    #1;
    check_output();
  endtask

  // exp_now is the value on data_to_proc during the store cycle itself.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic b,
                          input logic h, input logic [31:0] data, input logic [31:0] exp_now);
    @(posedge clock); #1;
    apply_stimulus(addr, 1'b1, b, h, 1'b0, data);
    push_expect(tag, exp_now);
    #1;
    check_output();
    @(posedge clock); #1;
    idle();
  endtask

  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (init_busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clock); #1;
    end
    check_value(tag, cnt, 32'd16);
  endtask

  task automatic check_all_words(input string tag);
    for (int i = 0; i < DEPTH; i++)
      do_load($sformatf("%s_w%0d", tag, i), 32'(4 * i), 1'b0, 1'b0, 1'b0, model[i]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    // Test 1: reset, then clear duration and an all-zero array.
    repeat (2) @(posedge clock);
    #1;
    check_value("busy_in_reset", {31'h0, init_busy}, 32'd1);
    check_value("count_in_reset", store_count, 32'd0);
    check_value("errm_in_reset", {31'h0, err_misaligned}, 32'd0);
    check_value("errr_in_reset", {31'h0, err_range}, 32'd0);
    reset = 1'b0;
    wait_clear("clear_len");
    check_all_words("zero");
    check_value("count_after_clear", store_count, 32'd0);

    // Test 2: a word store, then sub-word loads with and without sign extension.
    do_store("store_old_val", 32'h8, 1'b0, 1'b0, 32'h8091A2B3, 32'h0);
    model[2] = 32'h8091A2B3;
    do_load("word_8", 32'h8, 1'b0, 1'b0, 1'b0, 32'h8091A2B3);
    do_load("byte_9_sext", 32'h9, 1'b1, 1'b0, 1'b1, 32'hFFFFFF91);
    do_load("byte_9_zext", 32'h9, 1'b1, 1'b0, 1'b0, 32'h00000091);
    do_load("half_a_sext", 32'hA, 1'b0, 1'b1, 1'b1, 32'hFFFFA2B3);
    do_load("half_8_zext", 32'h8, 1'b0, 1'b1, 1'b0, 32'h00008091);
    do_load("byte_8_sext", 32'h8, 1'b1, 1'b0, 1'b1, 32'hFFFFFF80);
    do_load("byte_over_half", 32'hB, 1'b1, 1'b1, 1'b0, 32'h000000B3);
    check_value("count_1", store_count, 32'd1);

    // Test 3: byte and half stores touch only their lanes.
    do_store("bstore_old", 32'hB, 1'b1, 1'b0, 32'h000000EE, 32'h000000B3);
    model[2] = 32'h8091A2EE;
    do_load("word_8_after_b", 32'h8, 1'b0, 1'b0, 1'b0, 32'h8091A2EE);
    check_value("count_2", store_count, 32'd2);
    do_store("hstore_old", 32'h4, 1'b0, 1'b1, 32'h00001234, 32'h0);
    model[1] = 32'h12340000;
    do_load("word_4_after_h", 32'h4, 1'b0, 1'b0, 1'b0, 32'h12340000);

    // Test 4: a misaligned half store is dropped and the flag is sticky.
    check_value("errm_before", {31'h0, err_misaligned}, 32'd0);
    do_store("mis_store_data", 32'h5, 1'b0, 1'b1, 32'h0000BEEF, 32'h0);
    check_value("errm_set", {31'h0, err_misaligned}, 32'd1);
    check_value("errr_not_set", {31'h0, err_range}, 32'd0);
    do_load("word_4_kept", 32'h4, 1'b0, 1'b0, 1'b0, 32'h12340000);
    @(posedge clock); #1;
    check_value("errm_sticky", {31'h0, err_misaligned}, 32'd1);
    do_load("mis_word_load", 32'h6, 1'b0, 1'b0, 1'b0, 32'h0);
    check_value("count_3", store_count, 32'd3);

    // Test 5: an out-of-range store is dropped, and the array is unchanged.
    do_store("range_store_data", 32'h40, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
    check_value("errr_set", {31'h0, err_range}, 32'd1);
    check_value("count_still_3", store_count, 32'd3);
    check_all_words("after_range");

    // Test 6: reset again partway through the clear, with stores attempted while clearing.
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    apply_stimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);
    check_value("data_zero_in_clear", data_to_proc, 32'h0);
    repeat (7) @(posedge clock);
    #1;
    check_value("busy_mid_clear", {31'h0, init_busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_value("busy_rereset", {31'h0, init_busy}, 32'd1);
    reset = 1'b0;
    wait_clear("clear_len_restart");
    idle();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    check_all_words("recleared");
    check_value("count_after_rereset", store_count, 32'd0);
    check_value("errm_after_rereset", {31'h0, err_misaligned}, 32'd0);
    check_value("errr_after_rereset", {31'h0, err_range}, 32'd0);

    // An access that is both misaligned and out of range raises only err_range.
    do_load("range_mis_load", 32'h41, 1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clock); #1;
    check_value("errr_range_mis", {31'h0, err_range}, 32'd1);
    check_value("errm_range_mis", {31'h0, err_misaligned}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
